// File: rtl/p4_router_egress_port_demux.sv
// ---------------------------------------------------------------------------
// p4_router_egress_port_demux
//
// Purpose: steers whole packets from the VNP4 output stream to one of
// NUM_PORTS egress streams. The egress port (tuser LSBs) is decoded on the
// first beat of a packet and locked until tlast. Packets aimed at an
// out-of-range or disabled port are consumed and counted as drops.
// A single register slice drives the shared m_axis data bus with a one-hot
// per-port valid (1-cycle latency, full throughput).
//
// Optional feature macro: P4_ROUTER_EGR_DEMUX_STATS_EN
//   defined   -> per-port saturating forwarded-packet counters on pkt_count
//   undefined -> pkt_count tied to zero
//
// Ports:
//   clk, aresetn         clock, async active-low reset
//   port_enable          per-port enable, sampled at start of packet
//   stats_clear          pulse that zeroes all counters
//   s_axis_*             input stream, tuser = {ingress_port, egress_port}
//   m_axis_tdata/tkeep/tlast/tuser  shared output beat, tuser = ingress_port
//   m_axis_tvalid        one-hot per-port valid
//   m_axis_tready        per-port ready
//   drop_count           saturating dropped-packet count
//   pkt_count            per-port forwarded-packet counts (optional)
// ---------------------------------------------------------------------------
module p4_router_egress_port_demux #(
    parameter int DATA_BYTES     = 64,
    parameter int NUM_PORTS      = 4,
    parameter int EGR_PORT_WIDTH = 4,
    parameter int ING_PORT_WIDTH = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                   clk,
    input  logic                                   aresetn,
    input  logic [NUM_PORTS-1:0]                   port_enable,
    input  logic                                   stats_clear,
    input  logic [8*DATA_BYTES-1:0]                s_axis_tdata,
    input  logic [DATA_BYTES-1:0]                  s_axis_tkeep,
    input  logic                                   s_axis_tlast,
    input  logic [ING_PORT_WIDTH+EGR_PORT_WIDTH-1:0] s_axis_tuser,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    output logic [8*DATA_BYTES-1:0]                m_axis_tdata,
    output logic [DATA_BYTES-1:0]                  m_axis_tkeep,
    output logic                                   m_axis_tlast,
    output logic [ING_PORT_WIDTH-1:0]              m_axis_tuser,
    output logic [NUM_PORTS-1:0]                   m_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                   m_axis_tready,
    output logic [CNT_WIDTH-1:0]                   drop_count,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]         pkt_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Saturating counter step; a clear wins but still counts a coincident increment.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 clr,
        input logic                 inc
    );
        if (clr) begin
            return inc ? CNT_WIDTH'(1) : CNT_WIDTH'(0);
        end else if (inc && (cur != {CNT_WIDTH{1'b1}})) begin
            return cur + CNT_WIDTH'(1);
        end else begin
            return cur;
        end
    endfunction

    state_t                        state_r;
    logic [NUM_PORTS-1:0]          sel_r;      // one-hot port locked for the packet
    logic [ING_PORT_WIDTH-1:0]     ing_r;      // ingress port locked for the packet
    logic [NUM_PORTS-1:0]          tvalid_r;
    logic [8*DATA_BYTES-1:0]       tdata_r;
    logic [DATA_BYTES-1:0]         tkeep_r;
    logic                          tlast_r;
    logic [ING_PORT_WIDTH-1:0]     tuser_r;
    logic [CNT_WIDTH-1:0]          drop_r;

    logic [EGR_PORT_WIDTH-1:0]     egr_s;
    logic [ING_PORT_WIDTH-1:0]     ing_s;
    logic [NUM_PORTS-1:0]          egr_oh_s;
    logic                          sof_ok_s;
    logic                          drop_sof_s;
    logic                          drop_beat_s;
    logic                          out_hs_s;
    logic                          slot_free_s;
    logic                          in_hs_s;
    logic                          fwd_hs_s;
    logic [NUM_PORTS-1:0]          fwd_oh_s;
    logic [ING_PORT_WIDTH-1:0]     fwd_ing_s;

    assign egr_s = s_axis_tuser[EGR_PORT_WIDTH-1:0];
    assign ing_s = s_axis_tuser[ING_PORT_WIDTH+EGR_PORT_WIDTH-1:EGR_PORT_WIDTH];

    // Decode egress port to one-hot; out-of-range values decode to all zeros.
    always_comb begin
        egr_oh_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (32'(egr_s) == 32'(p)) begin
                egr_oh_s[p] = 1'b1;
            end else begin
                egr_oh_s[p] = 1'b0;
            end
        end
    end

    assign sof_ok_s    = |(egr_oh_s & port_enable);
    assign drop_sof_s  = (state_r == ST_IDLE) && !sof_ok_s;
    assign drop_beat_s = (state_r == ST_DROP) || drop_sof_s;

    // Slot can take a new beat when empty or when its beat leaves this cycle.
    assign out_hs_s    = |(tvalid_r & m_axis_tready);
    assign slot_free_s = !(|tvalid_r) || out_hs_s;

    // Dropped beats never touch the output slot, so they are always accepted.
    assign s_axis_tready = aresetn && (drop_beat_s || slot_free_s);
    assign in_hs_s       = s_axis_tvalid && s_axis_tready;
    assign fwd_hs_s      = in_hs_s && !drop_beat_s;

    assign fwd_oh_s  = (state_r == ST_IDLE) ? egr_oh_s : sel_r;
    assign fwd_ing_s = (state_r == ST_IDLE) ? ing_s    : ing_r;

    // Packet FSM, locked routing and the output register slice.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r  <= ST_IDLE;
            sel_r    <= '0;
            ing_r    <= '0;
            tvalid_r <= '0;
            tdata_r  <= '0;
            tkeep_r  <= '0;
            tlast_r  <= 1'b0;
            tuser_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_hs_s && sof_ok_s) begin
                        sel_r <= egr_oh_s;
                        ing_r <= ing_s;
                    end
                    if (in_hs_s && !s_axis_tlast) begin
                        state_r <= sof_ok_s ? ST_FWD : ST_DROP;
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (in_hs_s && s_axis_tlast) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase

            if (fwd_hs_s) begin
                tvalid_r <= fwd_oh_s;
                tdata_r  <= s_axis_tdata;
                tkeep_r  <= s_axis_tkeep;
                tlast_r  <= s_axis_tlast;
                tuser_r  <= fwd_ing_s;
            end else if (out_hs_s) begin
                tvalid_r <= '0;
            end
        end
    end

    // Dropped-packet counter, stepped once per dropped packet at its first beat.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            drop_r <= '0;
        end else begin
            drop_r <= cnt_next(drop_r, stats_clear, in_hs_s && drop_sof_s);
        end
    end

`ifdef P4_ROUTER_EGR_DEMUX_STATS_EN
    logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_r;

    // Per-port forwarded-packet counters, stepped on each output tlast handshake.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_r <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pkt_r[p*CNT_WIDTH +: CNT_WIDTH] <= cnt_next(pkt_r[p*CNT_WIDTH +: CNT_WIDTH],
                    stats_clear, tvalid_r[p] && m_axis_tready[p] && tlast_r);
            end
        end
    end

    assign pkt_count = pkt_r;
`else
    assign pkt_count = '0;
`endif

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tkeep  = tkeep_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tuser  = tuser_r;
    assign drop_count    = drop_r;

endmodule

// File: tb/tb_p4_router_egress_port_demux.sv
// ---------------------------------------------------------------------------
// Testbench for p4_router_egress_port_demux (default parameters).
// A packet-level model predicts per-port beat queues and counters from the
// routing rules; a negedge process compares counters and valid encoding each
// cycle, output beats are scored as they handshake, and directed sections
// pin latency, drop, stall, back-to-back and reset behaviour with literals.
// ---------------------------------------------------------------------------
module tb_p4_router_egress_port_demux;
    localparam int DB = 64;
    localparam int NP = 4;
    localparam int EW = 4;
    localparam int IW = 4;
    localparam int CW = 32;
    localparam int DW = 8 * DB;

    logic                 clk;
    logic                 aresetn;
    logic [NP-1:0]        port_enable;
    logic                 stats_clear;
    logic [DW-1:0]        s_tdata;
    logic [DB-1:0]        s_tkeep;
    logic                 s_tlast;
    logic [IW+EW-1:0]     s_tuser;
    logic                 s_tvalid;
    logic                 s_tready;
    logic [DW-1:0]        m_tdata;
    logic [DB-1:0]        m_tkeep;
    logic                 m_tlast;
    logic [IW-1:0]        m_tuser;
    logic [NP-1:0]        m_tvalid;
    logic [NP-1:0]        m_tready;
    logic [CW-1:0]        drop_count;
    logic [NP*CW-1:0]     pkt_count;

    p4_router_egress_port_demux #(
        .DATA_BYTES(DB), .NUM_PORTS(NP), .EGR_PORT_WIDTH(EW),
        .ING_PORT_WIDTH(IW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .aresetn(aresetn), .port_enable(port_enable), .stats_clear(stats_clear),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .drop_count(drop_count), .pkt_count(pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic [DB-1:0] k;
        logic          l;
        logic [IW-1:0] u;
    } beat_t;

    beat_t          expq [NP][$];
    int             m_state = 0;   // 0 between packets, 1 forwarding, 2 dropping
    int             m_sel   = 0;
    logic [IW-1:0]  m_ing   = '0;
    logic [CW-1:0]  m_drop  = '0;
    logic [CW-1:0]  m_pkt [NP];
    int             cyc     = 0;
    int             outcyc [$];

    function automatic logic [CW-1:0] upd(input logic [CW-1:0] cur, input logic clr, input logic inc);
        if (clr) return inc ? CW'(1) : CW'(0);
        if (inc && cur != {CW{1'b1}}) return cur + CW'(1);
        return cur;
    endfunction

    initial begin
        for (int p = 0; p < NP; p++) m_pkt[p] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!aresetn) begin
                for (int p = 0; p < NP; p++) begin
                    expq[p].delete();
                    m_pkt[p] = '0;
                end
                m_state = 0;
                m_drop  = '0;
            end else begin
                logic          dinc;
                logic [NP-1:0] pinc;
                beat_t         b;
                dinc = 1'b0;
                pinc = '0;
                for (int p = 0; p < NP; p++) begin
                    if (m_tvalid[p] && m_tready[p]) begin
                        outcyc.push_back(cyc);
                        if (expq[p].size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL out_unexpected: beat on port %0d got %0h expected none", p, m_tdata);
                        end else begin
                            b = expq[p].pop_front();
                            chk($sformatf("out_data_p%0d", p), m_tdata, b.d);
                            chk($sformatf("out_keep_p%0d", p), DW'(m_tkeep), DW'(b.k));
                            chk($sformatf("out_last_p%0d", p), DW'(m_tlast), DW'(b.l));
                            chk($sformatf("out_tuser_p%0d", p), DW'(m_tuser), DW'(b.u));
                            pinc[p] = b.l;
                        end
                    end
                end
                if (s_tvalid && s_tready) begin
                    int e;
                    e = int'(s_tuser[EW-1:0]);
                    b.d = s_tdata;
                    b.k = s_tkeep;
                    b.l = s_tlast;
                    if (m_state == 0) begin
                        if (e < NP && port_enable[e]) begin
                            m_sel = e;
                            m_ing = s_tuser[IW+EW-1:EW];
                            b.u   = m_ing;
                            expq[m_sel].push_back(b);
                            if (!s_tlast) m_state = 1;
                        end else begin
                            dinc = 1'b1;
                            if (!s_tlast) m_state = 2;
                        end
                    end else if (m_state == 1) begin
                        b.u = m_ing;
                        expq[m_sel].push_back(b);
                        if (s_tlast) m_state = 0;
                    end else begin
                        if (s_tlast) m_state = 0;
                    end
                end
                m_drop = upd(m_drop, stats_clear, dinc);
                for (int p = 0; p < NP; p++) m_pkt[p] = upd(m_pkt[p], stats_clear, pinc[p]);
            end
        end
    end

    // Per-cycle comparison of counters, valid encoding and drop-state ready.
    initial begin
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                chk("rst_tvalid", DW'(m_tvalid), DW'(0));
                chk("rst_tready", DW'(s_tready), DW'(0));
                chk("rst_drop", DW'(drop_count), DW'(0));
            end else begin
                chk("onehot_tvalid", DW'($countones(m_tvalid) <= 1), DW'(1));
                chk("drop_count", DW'(drop_count), DW'(m_drop));
`ifdef P4_ROUTER_EGR_DEMUX_STATS_EN
                for (int p = 0; p < NP; p++)
                    chk($sformatf("pkt_count_p%0d", p), DW'(pkt_count[p*CW +: CW]), DW'(m_pkt[p]));
`else
                chk("pkt_count_off", DW'(pkt_count), DW'(0));
`endif
                if (m_state == 2) chk("drop_tready", DW'(s_tready), DW'(1));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] mkd(input int s);
        logic [31:0] w;
        w = 32'hA5000000 ^ 32'(s);
        return {16{w}};
    endfunction

    task automatic drive_beat(input logic [IW+EW-1:0] u, input logic [DW-1:0] d, input logic l,
                              output int waits);
        bit ok;
        s_tvalid = 1'b1;
        s_tuser  = u;
        s_tdata  = d;
        s_tkeep  = l ? {{(DB-16){1'b0}}, {16{1'b1}}} : {DB{1'b1}};
        s_tlast  = l;
        ok       = 1'b0;
        waits    = 0;
        while (!ok && waits < 100) begin
            @(posedge clk);
            waits++;
            if (s_tready) ok = 1'b1;
        end
        #1;
        s_tvalid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL hs_timeout: got no tready after %0d cycles expected handshake", waits);
        end
    endtask

    task automatic send_pkt(input int egr, input int ing, input int n, input int seed);
        int w;
        for (int i = 0; i < n; i++)
            drive_beat({ing[IW-1:0], egr[EW-1:0]}, mkd(seed + i), (i == n - 1), w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int w;
        int got;
        logic [DW-1:0] held;
        aresetn     = 1'b0;
        port_enable = '1;
        stats_clear = 1'b0;
        m_tready    = '1;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tlast     = 1'b0;
        s_tuser     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tdata", m_tdata, DW'(0));
        @(posedge clk);
        #1 aresetn = 1'b1;
        idle(2);

        // 3-beat packet to port 2, ingress 5: one cycle latency
        drive_beat({4'd5, 4'd2}, mkd(100), 1'b0, w);
        @(negedge clk);
        chk("lat_tvalid", DW'(m_tvalid), DW'(4'b0100));
        chk("lat_tuser", DW'(m_tuser), DW'(4'd5));
        chk("lat_tdata", m_tdata, mkd(100));
        @(posedge clk);
        #1;
        drive_beat({4'd5, 4'd2}, mkd(101), 1'b0, w);
        drive_beat({4'd5, 4'd2}, mkd(102), 1'b1, w);
        idle(3);
`ifdef P4_ROUTER_EGR_DEMUX_STATS_EN
        chk("t1_pkt2", DW'(pkt_count[2*CW +: CW]), DW'(1));
`else
        chk("t1_pkt2", DW'(pkt_count[2*CW +: CW]), DW'(0));
`endif

        // egress 7 out of range: 4 beats each accepted immediately, one drop
        for (int i = 0; i < 4; i++) begin
            drive_beat({4'd1, 4'd7}, mkd(200 + i), (i == 3), w);
            chk("t2_drop_wait", DW'(w), DW'(1));
        end
        idle(2);
        chk("t2_drop_count", DW'(drop_count), DW'(1));

        // stats_clear alone zeroes the drop count
        stats_clear = 1'b1;
        idle(1);
        stats_clear = 1'b0;
        @(negedge clk);
        chk("clr_drop_count", DW'(drop_count), DW'(0));
        @(posedge clk);
        #1;

        // disabled port 1 drops, re-enabled port 1 forwards
        port_enable = 4'b1101;
        send_pkt(1, 2, 1, 300);
        idle(2);
        chk("t3_drop_count", DW'(drop_count), DW'(1));
        port_enable = 4'b1111;
        send_pkt(1, 2, 1, 310);
        @(negedge clk);
        chk("t3_fwd_tvalid", DW'(m_tvalid), DW'(4'b0010));
        idle(3);

        // back-to-back packets to ports 0 and 3: four consecutive output beats
        outcyc.delete();
        send_pkt(0, 3, 2, 400);
        send_pkt(3, 4, 2, 410);
        idle(4);
        chk("t4_out_beats", DW'(outcyc.size()), DW'(4));
        if (outcyc.size() == 4) chk("t4_no_bubble", DW'(outcyc[3] - outcyc[0]), DW'(3));

        // port 1 stalls 5 cycles mid-packet; egress field change on beat 2 ignored
        fork
            begin
                drive_beat({4'd6, 4'd1}, mkd(500), 1'b0, w);
                drive_beat({4'd6, 4'd3}, mkd(501), 1'b0, w);
                drive_beat({4'd6, 4'd3}, mkd(502), 1'b0, w);
                drive_beat({4'd6, 4'd0}, mkd(503), 1'b1, w);
            end
            begin
                got = 0;
                while (!m_tvalid[1] && got < 50) begin
                    @(negedge clk);
                    got++;
                end
                chk("t5_first_valid", DW'(m_tvalid[1]), DW'(1));
                m_tready[1] = 1'b0;
                held = m_tdata;
                repeat (5) begin
                    @(negedge clk);
                    chk("t5_stall_tready", DW'(s_tready), DW'(0));
                    chk("t5_hold_data", m_tdata, held);
                    chk("t5_hold_valid", DW'(m_tvalid), DW'(4'b0010));
                end
                m_tready[1] = 1'b1;
            end
        join
        idle(3);

        // reset mid-packet, then a clean packet to port 0
        drive_beat({4'd2, 4'd2}, mkd(600), 1'b0, w);
        drive_beat({4'd2, 4'd2}, mkd(601), 1'b0, w);
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk("t6_rst_tvalid", DW'(m_tvalid), DW'(0));
        chk("t6_rst_tready", DW'(s_tready), DW'(0));
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        idle(2);
        send_pkt(0, 1, 2, 700);
        idle(3);

        // drop, then a drop coincident with stats_clear leaves the count at 1
        send_pkt(9, 0, 1, 800);
        idle(1);
        stats_clear = 1'b1;
        drive_beat({4'd0, 4'd9}, mkd(810), 1'b1, w);
        stats_clear = 1'b0;
        chk("t7_drop_wait", DW'(w), DW'(1));
        @(negedge clk);
        chk("t7_clr_inc", DW'(drop_count), DW'(1));

        idle(5);
        for (int p = 0; p < NP; p++)
            chk($sformatf("end_queue_p%0d", p), DW'(expq[p].size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
